inv_key_schedule: RTL and testbench
===================================

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; 10 is the only supported value.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  load key_in and begin a reverse schedule; sampled only in IDLE.
REQ-005 SHALL have port key_in  input  128  final (round-NR) round key, w0 in [127:96] through w3 in [31:0].
REQ-006 SHALL have port out_ready  input  1  consumer accepts key_out this cycle.
REQ-007 SHALL have port valid  output  1  key_out/round hold a valid round key.
REQ-008 SHALL have port key_out  output  128  current round key, same word packing as key_in.
REQ-009 SHALL have port round  output  4  round index of key_out, NR down to 0.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after round-0 key is accepted.

Function
REQ-012 SHALL implement states IDLE and EMIT.
REQ-013 In IDLE with start=1, SHALL on the next edge register key_out=key_in, round=NR, valid=1, busy=1, and enter EMIT.
REQ-014 SHALL treat start as ignored in EMIT; an in-flight schedule is never restarted.
REQ-015 A handshake SHALL occur on any edge where valid=1 and out_ready=1.
REQ-016 If valid=1 and out_ready=0, key_out and round SHALL hold their values unchanged.
REQ-017 On a handshake with round>0, SHALL register the previous round key and round-1 the next cycle (one key per cycle at full throughput; valid stays 1).
REQ-018 Previous key SHALL be: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon(round).
REQ-019 RotWord SHALL be a left byte rotation by 8 bits; SubWord SHALL apply the AES forward S-box to each byte.
REQ-020 Rcon(r) SHALL be {rc,24'h0} with rc = 01,02,04,08,10,20,40,80,1b,36 for r=1..10.
REQ-021 On a handshake with round=0, SHALL return to IDLE with valid=0, busy=0, and done=1 for exactly that next cycle.
REQ-022 In IDLE, key_out SHALL retain the last round-0 key; round SHALL read 0.
REQ-023 If start=1 on the same cycle that done=1, the state is IDLE, so SHALL accept it per REQ-013.

Reset
REQ-024 rst=1 on any edge SHALL force IDLE, valid=0, busy=0, done=0, round=0, and key_out=0, overriding start and handshakes.
REQ-025 Reset mid-schedule SHALL discard the schedule; the next start after reset SHALL begin cleanly at round NR.

Configuration
REQ-026 With ROUNDKEY_BUF_EN defined, SHALL add input rd_addr[3:0] and output rd_key[127:0], and an 11-entry buffer written with key_out at the index given by round on each handshake.
REQ-027 With ROUNDKEY_BUF_EN, rd_key SHALL combinationally return entry rd_addr; for rd_addr>10 it SHALL return 0, and all entries SHALL reset to 0.
REQ-028 Without ROUNDKEY_BUF_EN, SHALL omit those ports and the buffer; all other behaviour is identical.

Verification
REQ-029 Start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and out_ready=1 -> round 10 shows that key; round 9 key is ac7766f319fadc2128d12941575c006e; round 1 key is a0fafe1788542cb123a339392a6c7605; round 0 key is 2b7e151628aed2a6abf7158809cf4f3c; done pulses once; 11 valid cycles total.
REQ-030 Same key with out_ready toggling pseudo-randomly -> identical 11-key sequence, no key skipped or repeated, and key_out stable while stalled.
REQ-031 Pulse start during EMIT at round 5 -> ignored; the sequence continues to round 0 unchanged.
REQ-032 Assert rst at round 6 -> next cycle valid=0, busy=0, key_out=0; a following start reproduces the full REQ-029 sequence.
REQ-033 Assert start in the cycle where done=1 -> a new schedule begins at round 10 on the next edge.
REQ-034 With ROUNDKEY_BUF_EN, after REQ-029 -> rd_addr=0 gives 2b7e1516...4f3c, rd_addr=10 gives d014f9a8...0ca6, rd_addr=15 gives 0.

Source files
------------

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: walks from the round-NR key down to round 0, one key per handshake.
// Optional ROUNDKEY_BUF_EN adds an 11-entry buffer of emitted round keys readable through rd_addr/rd_key.
module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         out_ready,
  output logic         valid,
  output logic [127:0] key_out,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
`ifdef ROUNDKEY_BUF_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'd0};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic [127:0] prev_key;
  logic [31:0]  w0n, w1n, w2n, w3n, rot_w, sub_w;
  logic         handshake;

  assign handshake = (state_q == EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Undo one expansion step: earlier words fall out of XORs of adjacent later words.
  always_comb begin
    w3n   = key_q[31:0]  ^ key_q[63:32];
    w2n   = key_q[63:32] ^ key_q[95:64];
    w1n   = key_q[95:64] ^ key_q[127:96];
    rot_w = {w3n[23:0], w3n[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    w0n   = key_q[127:96] ^ sub_w ^ {rcon(round_q), 24'h0};
    prev_key = {w0n, w1n, w2n, w3n};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          key_d   = key_in;
          round_d = 4'(NR);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid   = (state_q == EMIT);
    busy    = (state_q != IDLE);
    key_out = key_q;
    round   = round_q;
    done    = done_q;
  end

`ifdef ROUNDKEY_BUF_EN
  logic [127:0] buf_q [0:10];
  logic [127:0] buf_d [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < 11; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 11; i++) buf_d[i] = buf_q[i];
    if (handshake && (round_q <= 4'd10)) buf_d[round_q] = key_q;
  end

  always_comb begin
    rd_key = '0;
    if (rd_addr <= 4'd10) rd_key = buf_q[rd_addr];
  end
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule; expected keys come from a forward AES-128 expansion
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_inv_key_schedule;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         out_ready = 1'b1;
  logic         valid;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic         busy;
  logic         done;
`ifdef ROUNDKEY_BUF_EN
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_key;
`endif

  int           total = 0;
  int           bad = 0;
  int           hs_count = 0;
  int           done_count = 0;
  logic         ready_random = 1'b0;
  exp_t         exp_q[$];
  logic [7:0]   sbox_m [256];
  logic [127:0] model_keys [11];

  localparam logic [127:0] VEC_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] VEC_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] VEC_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] VEC_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  inv_key_schedule #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .out_ready (out_ready),
    .valid     (valid),
    .key_out   (key_out),
    .round     (round),
    .busy      (busy),
    .done      (done)
`ifdef ROUNDKEY_BUF_EN
    ,
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[a] = s;
    end
  endtask

  // Forward expansion from the cipher key; the DUT must emit these keys in reverse order.
  task automatic expandKey(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k0[127:96];
    w[1] = k0[95:64];
    w[2] = k0[63:32];
    w[3] = k0[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic applyStimulus(input logic [127:0] k10, input bit use_vec);
    exp_t e;
    start  = 1'b1;
    key_in = k10;
    for (int r = 10; r >= 0; r--) begin
      e.key = model_keys[r];
      e.rnd = 4'(r);
      if (use_vec) begin
        if (r == 10) e.key = VEC_K10;
        if (r == 9)  e.key = VEC_K9;
        if (r == 1)  e.key = VEC_K1;
        if (r == 0)  e.key = VEC_K0;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL %s timeout waiting for idle, busy=%0b pending=%0d", name, busy, exp_q.size());
    exp_q.delete();
  endtask

  task automatic waitRound(input logic [3:0] r);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (valid && round == r) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL wait_round timeout actual=%0d required=%0d", round, r);
  endtask

  task automatic waitDone();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL wait_done timeout actual=%0b required=1", done);
  endtask

  task automatic runVector(input string name, input bit rand_ready);
    int h0, d0;
    expandKey(VEC_K0);
    ready_random = rand_ready;
    h0 = hs_count;
    d0 = done_count;
    applyStimulus(VEC_K10, 1'b1);
    waitIdle(name);
    ready_random = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, "_key_count"}, 128'(hs_count - h0), 128'd11);
    checkOutput({name, "_done_pulses"}, 128'(done_count - d0), 128'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_random ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stalls, done and idle behaviour.
  initial begin
    logic         pend_done;
    logic         stalled;
    logic [127:0] held_key;
    logic [3:0]   held_round;
    logic [127:0] last_r0;
    exp_t         e;
    pend_done = 1'b0;
    stalled   = 1'b0;
    held_key  = '0;
    held_round = '0;
    last_r0   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 1'b0;
        stalled   = 1'b0;
        continue;
      end
      if (pend_done) begin
        checkOutput("done_pulse", 128'(done), 128'd1);
        checkOutput("valid_after_last", 128'(valid), 128'd0);
        checkOutput("idle_key_retained", key_out, last_r0);
        checkOutput("idle_round", 128'(round), 128'd0);
        pend_done = 1'b0;
      end else begin
        checkOutput("done_idle", 128'(done), 128'd0);
      end
      checkOutput("busy", 128'(busy), 128'(valid));
      if (stalled) begin
        checkOutput("stall_key", key_out, held_key);
        checkOutput("stall_round", 128'(round), 128'(held_round));
      end
      stalled = 1'b0;
      if (valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_valid actual round=%0d required=no output", round);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          checkOutput("key", key_out, e.key);
          checkOutput("round", 128'(round), 128'(e.rnd));
          hs_count++;
          if (e.rnd == 4'd0) begin
            pend_done = 1'b1;
            last_r0   = e.key;
          end
        end else begin
          stalled    = 1'b1;
          held_key   = key_out;
          held_round = round;
        end
      end
      if (done) done_count++;
    end
  end

  initial begin
    logic [127:0] k;
    buildSbox();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 128'(valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_done", 128'(done), 128'd0);
    checkOutput("reset_round", 128'(round), 128'd0);
    checkOutput("reset_key", key_out, 128'd0);
    rst = 1'b0;

    runVector("vector_full_rate", 1'b0);
    runVector("vector_stalled", 1'b1);

    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expandKey(k);
      ready_random = 1'b1;
      applyStimulus(model_keys[10], 1'b0);
      waitIdle("random_key");
      ready_random = 1'b0;
    end

    expandKey(VEC_K0);
    applyStimulus(VEC_K10, 1'b1);
    waitRound(4'd5);
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle("start_ignored");

    applyStimulus(VEC_K10, 1'b1);
    waitRound(4'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_valid", 128'(valid), 128'd0);
    checkOutput("midreset_busy", 128'(busy), 128'd0);
    checkOutput("midreset_key", key_out, 128'd0);
    checkOutput("midreset_round", 128'(round), 128'd0);
    rst = 1'b0;
    exp_q.delete();
    runVector("after_reset", 1'b0);

`ifdef ROUNDKEY_BUF_EN
    rd_addr = 4'd0;
    #1;
    checkOutput("buf_addr0", rd_key, VEC_K0);
    rd_addr = 4'd10;
    #1;
    checkOutput("buf_addr10", rd_key, VEC_K10);
    rd_addr = 4'd9;
    #1;
    checkOutput("buf_addr9", rd_key, VEC_K9);
    rd_addr = 4'd15;
    #1;
    checkOutput("buf_addr15", rd_key, 128'd0);
`endif

    applyStimulus(VEC_K10, 1'b1);
    waitDone();
    k = {$urandom, $urandom, $urandom, $urandom};
    expandKey(k);
    applyStimulus(model_keys[10], 1'b0);
    checkOutput("restart_on_done_round", 128'(round), 128'd10);
    checkOutput("restart_on_done_valid", 128'(valid), 128'd1);
    waitIdle("restart_on_done");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
